// File: rtl/demux_scatter_pkg.sv
// Shared constants and types for the 1-to-8 scatter demultiplexer.
package demux_scatter_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef logic [SEL_W-1:0] sel_t;

  // The round-robin pointer advances modulo NUM_CH; the 3-bit field wraps 7 -> 0 by itself.
  function automatic sel_t next_ptr(input sel_t p);
    return p + sel_t'(1);
  endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One output channel: a data register and the flag saying it holds an unconsumed word.
module demux_chan_reg
  import demux_scatter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic             ack,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  // NOTE: the data register is reset too, so a reset discards held words and out_data reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (wr) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      dout  <= din;
      valid <= 1'b1;
    end else if (ack) begin
      // An ack on an empty channel leaves valid at 0, so it needs no gating here.
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_scatter8.sv
// Scatters one input stream over 8 single-entry channels, by sel or round-robin pointer.
// Optional broadcast port enabled by `define DEMUX_SCATTER_BCAST_EN.
module demux_scatter8
  import demux_scatter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    auto_mode,
`ifdef DEMUX_SCATTER_BCAST_EN
  input  logic                    bcast,
`endif
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ack,
  output logic [SEL_W-1:0]        ptr
);

  sel_t              target;
  logic [NUM_CH-1:0] free;
  logic [NUM_CH-1:0] wr;
  logic              accept;
  logic              bcast_en;

`ifdef DEMUX_SCATTER_BCAST_EN
  assign bcast_en = bcast;
`else
  assign bcast_en = 1'b0;
`endif

  assign target = auto_mode ? ptr : sel;

  // A channel can take a word if it is empty or is being drained in this same cycle.
  assign free     = ~out_valid | out_ack;
  assign in_ready = bcast_en ? (&free) : free[target];
  assign accept   = in_valid & in_ready;

  always_comb begin
    // NOTE: default first so every path assigns wr and no latch is inferred.
    wr = '0;
    if (accept) begin
      if (bcast_en) wr = '1;
      else          wr[target] = 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    demux_chan_reg #(.WIDTH(WIDTH)) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (wr[k]),
      .ack   (out_ack[k]),
      .din   (in_data),
      .dout  (out_data[k*WIDTH +: WIDTH]),
      .valid (out_valid[k])
    );
  end

  // Broadcast writes every channel, so the round-robin position is left where it was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (accept && auto_mode && !bcast_en)
      ptr <= next_ptr(ptr);
  end

endmodule

// File: tb/tb_demux_scatter8.sv
// Randomized self-checking bench for demux_scatter8 against an array-based channel model.
module tb_demux_scatter8;

  localparam int W  = 8;
  localparam int NC = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    sel;
  logic          auto_mode;
  logic          bcast;
  logic [NC*W-1:0] out_data;
  logic [NC-1:0] out_valid;
  logic [NC-1:0] out_ack;
  logic [2:0]    ptr;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: what each channel holds, whether it is full, and the pointer.
  logic [W-1:0] m_data [NC];
  bit           m_full [NC];
  int           m_ptr;

  always #5 clk = ~clk;

  demux_scatter8 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .auto_mode (auto_mode),
`ifdef DEMUX_SCATTER_BCAST_EN
    .bcast     (bcast),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .ptr       (ptr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      m_data[k] = '0;
      m_full[k] = 1'b0;
    end
    m_ptr = 0;
  endtask

  function automatic bit model_ready();
    int t;
    bit ok;
    if (bcast) begin
      ok = 1'b1;
      for (int k = 0; k < NC; k++) if (m_full[k] && !out_ack[k]) ok = 1'b0;
      return ok;
    end
    t = auto_mode ? m_ptr : int'(sel);
    return !m_full[t] || out_ack[t];
  endfunction

  task automatic check_state(input string tag);
    logic [NC*W-1:0] e_data;
    logic [NC-1:0]   e_valid;
    for (int k = 0; k < NC; k++) begin
      e_data[k*W +: W] = m_data[k];
      e_valid[k]       = m_full[k];
    end
    check({tag, ".out_valid"}, 64'(out_valid), 64'(e_valid));
    check({tag, ".out_data"},  64'(out_data),  64'(e_data));
    check({tag, ".ptr"},       64'(ptr),       64'(m_ptr));
  endtask

  // Inputs are already driven; check in_ready, take one edge, then check the state.
  task automatic step(input string tag);
    bit rdy;
    bit take;
    int t;
    #1;
    rdy = model_ready();
    if (rst_n) check({tag, ".in_ready"}, 64'(in_ready), 64'(rdy));
    take = rst_n && in_valid && rdy;
    t = auto_mode ? m_ptr : int'(sel);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < NC; k++) begin
        if (take && (bcast || k == t)) begin
          m_data[k] = in_data;
          m_full[k] = 1'b1;
        end else if (out_ack[k]) begin
          m_full[k] = 1'b0;
        end
      end
      if (take && auto_mode && !bcast) m_ptr = (m_ptr + 1) % NC;
    end
    #1;
    check_state(tag);
  endtask

  task automatic drive(input bit v, input logic [W-1:0] d, input logic [2:0] s,
                       input bit a, input logic [NC-1:0] ack);
    in_valid  = v;
    in_data   = d;
    sel       = s;
    auto_mode = a;
    out_ack   = ack;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state("reset_async");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    bcast = 1'b0;
    drive(0, '0, '0, 0, '0);
    #2;
    do_reset();
    check("reset.in_ready", 64'(in_ready), 64'(1));

    // Single write to channel 3.
    drive(1, 8'hA5, 3'd3, 0, '0);
    step("sel3_write");
    check("sel3.valid_exact", 64'(out_valid), 64'h08);
    check("sel3.data_exact", 64'(out_data[3*W +: W]), 64'hA5);

    // Channel 3 full: stall with held word, then same-cycle ack-and-reload.
    drive(1, 8'h5A, 3'd3, 0, '0);
    step("ch3_stall");
    check("ch3_stall.kept", 64'(out_data[3*W +: W]), 64'hA5);
    drive(1, 8'h5A, 3'd3, 0, 8'h08);
    step("ch3_ack_reload");
    check("ch3_reload.data", 64'(out_data[3*W +: W]), 64'h5A);
    drive(0, '0, '0, 0, 8'h08);
    step("ch3_drain");

    // Round-robin: nine words with all acks held.
    for (int i = 0; i < 9; i++) begin
      drive(1, W'(i), '0, 1, '1);
      step("rr_burst");
    end
    check("rr.ptr_end", 64'(ptr), 64'd1);
    check("rr.ch0_word8", 64'(out_data[0 +: W]), 64'd8);
    drive(0, '0, '0, 1, '1);
    step("rr_drain");

    // Bring ptr to 5 with channel 5 full, then stall on it.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, W'(8'h10 + i), '0, 1, 8'h1F);
      step("to_ptr5");
    end
    drive(1, 8'h55, 3'd5, 0, 8'h1F);
    step("fill_ch5");
    drive(1, 8'h66, 3'd0, 1, '0);
    step("ptr5_stall");
    check("ptr5_stall.ptr", 64'(ptr), 64'd5);
    drive(1, 8'h66, 3'd0, 1, 8'h20);
    step("ptr5_ack");
    check("ptr5_ack.ptr", 64'(ptr), 64'd6);

    // Reset mid-transfer with several channels full.
    drive(1, 8'h77, 3'd1, 0, '0);
    step("fill_ch1");
    drive(1, 8'h78, 3'd2, 0, '0);
    step("fill_ch2");
    drive(1, 8'h79, 3'd7, 0, '0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state("midreset_async");
    step("reset_edge_no_write");
    #3;
    rst_n = 1'b1;

`ifdef DEMUX_SCATTER_BCAST_EN
    bcast = 1'b1;
    drive(1, 8'h3C, '0, 0, '0);
    step("bcast_all");
    check("bcast.valid_exact", 64'(out_valid), 64'hFF);
    bcast = 1'b0;
    drive(0, '0, '0, 0, 8'hFB);
    step("bcast_drain");
    bcast = 1'b1;
    drive(1, 8'hC3, '0, 0, '0);
    step("bcast_blocked");
    bcast = 1'b0;
`endif

    // Random traffic with sparse acks so stalls are frequent.
    for (int i = 0; i < 400; i++) begin
      logic [NC-1:0] ack;
      for (int k = 0; k < NC; k++) ack[k] = ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 3) != 0, W'($urandom), 3'($urandom), $urandom_range(0, 1) == 1, ack);
`ifdef DEMUX_SCATTER_BCAST_EN
      bcast = ($urandom_range(0, 15) == 0);
`endif
      if (i == 200) begin
        rst_n = 1'b0;
        step("rand_reset");
        #3;
        rst_n = 1'b1;
      end else begin
        step("random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
